// File: rtl/kernel_kcore_start_fifo_ctl_if.sv
// Purpose: bundles the producer/consumer handshake, data and status signals
//          of the start/token FIFO. The FIFO takes the slave modport. The
//          process that drives the FIFO takes the master modport.
// Ports (signals carried):
//   if_read_ce, if_read, if_write_ce, if_write, if_din, if_flush -> into FIFO
//   if_empty_n, if_dout, if_full_n, if_count, if_almost_full,
//   if_almost_empty, if_err_overflow, if_err_underflow           -> out of FIFO
interface kernel_kcore_start_fifo_ctl_if #(
    parameter int DATA_WIDTH = 1,
    parameter int CNT_WIDTH  = 3
);
    logic                  if_empty_n;
    logic                  if_read_ce;
    logic                  if_read;
    logic [DATA_WIDTH-1:0] if_dout;
    logic                  if_full_n;
    logic                  if_write_ce;
    logic                  if_write;
    logic [DATA_WIDTH-1:0] if_din;
    logic                  if_flush;
    logic [CNT_WIDTH-1:0]  if_count;
    logic                  if_almost_full;
    logic                  if_almost_empty;
    logic                  if_err_overflow;
    logic                  if_err_underflow;

    modport slave (
        input  if_read_ce, if_read, if_write_ce, if_write, if_din, if_flush,
        output if_empty_n, if_dout, if_full_n, if_count, if_almost_full,
               if_almost_empty, if_err_overflow, if_err_underflow
    );

    modport master (
        output if_read_ce, if_read, if_write_ce, if_write, if_din, if_flush,
        input  if_empty_n, if_dout, if_full_n, if_count, if_almost_full,
               if_almost_empty, if_err_overflow, if_err_underflow
    );
endinterface

// File: rtl/kernel_kcore_start_fifo_ctl.sv
// Purpose: shift-register start/token FIFO that sits between two HLS dataflow
//          processes. It supports any DEPTH >= 2. It also provides an occupancy
//          count, registered almost-full and almost-empty flags, a synchronous
//          flush, and sticky overflow and underflow diagnostics.
// Ports:
//   clk     - rising-edge clock
//   reset_n - asynchronous active-low reset
//   bus     - slave modport of kernel_kcore_start_fifo_ctl_if. It carries the
//             producer/consumer handshake, the data and the status flags.
module kernel_kcore_start_fifo_ctl #(
    parameter int DATA_WIDTH = 1,
    parameter int DEPTH      = 4,
    parameter int CNT_WIDTH  = 3,
    parameter int AF_LEVEL   = 3,
    parameter int AE_LEVEL   = 1
) (
    input  logic                         clk,
    input  logic                         reset_n,
    kernel_kcore_start_fifo_ctl_if.slave bus
);
    localparam int IDX_W = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];
    logic [CNT_WIDTH-1:0]  count_q, count_d;
    logic                  empty_n_q, empty_n_d;
    logic                  full_n_q, full_n_d;
    logic                  af_q, af_d;
    logic                  ae_q, ae_d;
    logic                  ovf_q, ovf_d;
    logic                  udf_q, udf_d;

    logic                  wr_req, rd_req, push, pop;
    logic [IDX_W-1:0]      rd_idx;

    // NOTE: every variable written here gets a default first, so no path
    // through the block leaves a value unassigned and no latch can be inferred.
    always_comb begin
        wr_req  = bus.if_write & bus.if_write_ce;
        rd_req  = bus.if_read & bus.if_read_ce;
        // Requests are gated by the registered flags. A write when full or a
        // read when empty is dropped here and is never queued. A flush
        // overrides both requests.
        push    = wr_req & full_n_q & ~bus.if_flush;
        pop     = rd_req & empty_n_q & ~bus.if_flush;

        count_d = count_q;
        if (bus.if_flush) begin
            count_d = '0;
        end else if (push && !pop) begin
            count_d = count_q + CNT_WIDTH'(1);
        end else if (pop && !push) begin
            count_d = count_q - CNT_WIDTH'(1);
        end

        // The flags are computed from the next count, so each registered flag
        // matches the count in the cycle where that count takes effect.
        empty_n_d = (count_d != '0);
        full_n_d  = (count_d != CNT_WIDTH'(DEPTH));
        af_d      = (count_d >= CNT_WIDTH'(AF_LEVEL));
        ae_d      = (count_d <= CNT_WIDTH'(AE_LEVEL));

        // The error flags are diagnostic only. They look at the raw requests,
        // so a flush does not mask them.
        ovf_d = ovf_q | (wr_req & ~full_n_q);
        udf_d = udf_q | (rd_req & ~empty_n_q);

        // A push shifts every slot up by one and writes din into slot 0. The
        // head sits at slot count-1, so on a push together with a pop it
        // naturally moves to the next-oldest entry.
        mem_d = mem_q;
        if (push) begin
            mem_d[0] = bus.if_din;
            for (int i = 1; i < DEPTH; i++) begin
                mem_d[i] = mem_q[i-1];
            end
        end

        rd_idx = (count_q != '0) ? IDX_W'(count_q - CNT_WIDTH'(1)) : '0;
    end

    // NOTE: sequential state uses non-blocking assignments only. All flops
    // then sample the values from before the edge, with no dependence on
    // process ordering.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q   <= '0;
            empty_n_q <= 1'b0;
            full_n_q  <= 1'b1;
            af_q      <= 1'b0;
            ae_q      <= 1'b1;
            ovf_q     <= 1'b0;
            udf_q     <= 1'b0;
        end else begin
            count_q   <= count_d;
            empty_n_q <= empty_n_d;
            full_n_q  <= full_n_d;
            af_q      <= af_d;
            ae_q      <= ae_d;
            ovf_q     <= ovf_d;
            udf_q     <= udf_d;
        end
    end

    // NOTE: the storage array has no reset. The count alone decides validity,
    // and leaving the array unreset keeps the reset tree off the data flops.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign bus.if_empty_n       = empty_n_q;
    assign bus.if_full_n        = full_n_q;
    assign bus.if_count         = count_q;
    assign bus.if_almost_full   = af_q;
    assign bus.if_almost_empty  = ae_q;
    assign bus.if_err_overflow  = ovf_q;
    assign bus.if_err_underflow = udf_q;
    assign bus.if_dout          = mem_q[rd_idx];
endmodule

// File: tb/tb_kernel_kcore_start_fifo_ctl.sv
module tb_kernel_kcore_start_fifo_ctl;
    localparam int DW    = 8;
    localparam int DEPTH = 5;
    localparam int CW    = 3;
    localparam int AF    = 3;
    localparam int AE    = 1;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    kernel_kcore_start_fifo_ctl_if #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) bus ();

    kernel_kcore_start_fifo_ctl #(
        .DATA_WIDTH(DW), .DEPTH(DEPTH), .CNT_WIDTH(CW),
        .AF_LEVEL(AF), .AE_LEVEL(AE)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // Reference model: a queue of tokens with the oldest at the front, plus two sticky bits.
    logic [DW-1:0] model_q[$];
    bit            m_ovf, m_udf;
    int            n_tests = 0;
    int            n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        int sz;
        sz = model_q.size();
        check({tag, ".count"}, 32'(bus.if_count), 32'(sz));
        check({tag, ".empty_n"}, 32'(bus.if_empty_n), 32'(sz > 0));
        check({tag, ".full_n"}, 32'(bus.if_full_n), 32'(sz < DEPTH));
        check({tag, ".af"}, 32'(bus.if_almost_full), 32'(sz >= AF));
        check({tag, ".ae"}, 32'(bus.if_almost_empty), 32'(sz <= AE));
        check({tag, ".ovf"}, 32'(bus.if_err_overflow), 32'(m_ovf));
        check({tag, ".udf"}, 32'(bus.if_err_underflow), 32'(m_udf));
        if (sz > 0) check({tag, ".dout"}, 32'(bus.if_dout), 32'(model_q[0]));
    endtask

    task automatic drive(input bit w, input bit r, input logic [DW-1:0] din, input bit fl);
        bus.if_write    = w;
        bus.if_write_ce = 1'b1;
        bus.if_read     = r;
        bus.if_read_ce  = 1'b1;
        bus.if_din      = din;
        bus.if_flush    = fl;
    endtask

    // Advance one clock edge, update the model from the driven inputs, then check all outputs 1 ns later.
    task automatic cycle(input string tag);
        bit wreq, rreq;
        int sz;
        @(posedge clk);
        wreq = bus.if_write && bus.if_write_ce;
        rreq = bus.if_read && bus.if_read_ce;
        sz   = model_q.size();
        if (wreq && sz == DEPTH) m_ovf = 1'b1;
        if (rreq && sz == 0)     m_udf = 1'b1;
        if (bus.if_flush) begin
            model_q.delete();
        end else begin
            if (rreq && sz > 0)     void'(model_q.pop_front());
            if (wreq && sz < DEPTH) model_q.push_back(bus.if_din);
        end
        #1;
        check_all(tag);
    endtask

    task automatic model_reset();
        model_q.delete();
        m_ovf = 1'b0;
        m_udf = 1'b0;
    endtask

    initial begin
        // 1: reset held low with random inputs.
        model_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1'($urandom), 1'($urandom), 8'($urandom), 1'($urandom));
            bus.if_write_ce = 1'($urandom);
            bus.if_read_ce  = 1'($urandom);
            @(posedge clk); #1;
            check_all("reset");
        end
        drive(0, 0, 8'h00, 0);
        @(negedge clk);
        reset_n = 1'b1;

        // 2: fill with 0x11..0x55, then drain in order.
        for (int i = 1; i <= DEPTH; i++) begin
            drive(1, 0, 8'(i * 8'h11), 0);
            cycle("fill");
        end
        check("fill_full_n", 32'(bus.if_full_n), 32'd0);
        for (int i = 1; i <= DEPTH; i++) begin
            check("drain_dout", 32'(bus.if_dout), 32'(i * 8'h11));
            drive(0, 1, 8'h00, 0);
            cycle("drain");
        end

        // 3: full, with write and read together; the write is rejected.
        for (int i = 1; i <= DEPTH; i++) begin
            drive(1, 0, 8'(i * 8'h11), 0);
            cycle("refill");
        end
        drive(1, 1, 8'h66, 0);
        cycle("full_wr_rd");
        check("full_wr_rd_count", 32'(bus.if_count), 32'd4);
        check("full_wr_rd_ovf", 32'(bus.if_err_overflow), 32'd1);
        check("full_wr_rd_head", 32'(bus.if_dout), 32'h22);
        for (int i = 0; i < 4; i++) begin
            check("no_66", 32'(bus.if_dout == 8'h66), 32'd0);
            drive(0, 1, 8'h00, 0);
            cycle("drain2");
        end

        // 4: empty, with write and read together; the read is rejected.
        drive(1, 1, 8'hA5, 0);
        cycle("empty_wr_rd");
        check("empty_wr_rd_count", 32'(bus.if_count), 32'd1);
        check("empty_wr_rd_udf", 32'(bus.if_err_underflow), 32'd1);
        check("empty_wr_rd_dout", 32'(bus.if_dout), 32'hA5);
        drive(0, 1, 8'h00, 0);
        cycle("pop_a5");

        // 5: threshold sweep, count 0..5..0 (flags are checked every cycle).
        for (int i = 0; i < DEPTH; i++) begin
            drive(1, 0, 8'($urandom), 0);
            cycle("thr_up");
        end
        for (int i = 0; i < DEPTH; i++) begin
            drive(0, 1, 8'h00, 0);
            cycle("thr_dn");
        end

        // 6: flush at count 3 with a concurrent write, then a reset pulse mid-stream.
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 8'($urandom), 0);
            cycle("pre_flush");
        end
        drive(1, 0, 8'hEE, 1);
        cycle("flush");
        check("flush_count", 32'(bus.if_count), 32'd0);
        check("flush_empty_n", 32'(bus.if_empty_n), 32'd0);
        drive(1, 0, 8'h5A, 0);
        cycle("post_flush");
        drive(1, 0, 8'h5B, 0);
        cycle("post_flush2");
        #2 reset_n = 1'b0;
        model_reset();
        #1 check_all("async_reset");
        @(negedge clk);
        reset_n = 1'b1;
        drive(0, 0, 8'h00, 0);
        cycle("after_reset");

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom), 1'($urandom), 8'($urandom), ($urandom_range(0, 31) == 0));
            bus.if_write_ce = ($urandom_range(0, 7) != 0);
            bus.if_read_ce  = ($urandom_range(0, 7) != 0);
            cycle("rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
